// File: rtl/shift_ctrl.sv
// shift_ctrl: serial-to-parallel frame capture controlled by an upstream sync FSM.
//
// A frame starts from IDLE when sync_state is high. The block then shifts in
// len_eff bits from sdin (len of 0 or above WIDTH means WIDTH). It presents the
// frame right-aligned on dout with dout_valid, and holds it until dout_ready.
// If sync_state drops before the last bit, the frame is abandoned. In that case
// a one-cycle fsm_rst pulse goes back to the sync FSM, and abort_cnt counts the
// abort (saturating).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   sync_state        1 = upstream frame active
//   sdin              serial data bit
//   len               frame length in bits (sampled on frame start only)
//   dout_ready        downstream accept
//   sh_en             shift enable back to the sync FSM (registered)
//   fsm_rst           one-cycle abort pulse to the sync FSM (registered)
//   dout, dout_valid  captured frame and its valid flag (registered)
//   busy              not in IDLE
//   abort_cnt         saturating count of aborted frames
module shift_ctrl #(
  parameter int WIDTH = 64,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_state,
  input  logic             sdin,
  input  logic [LEN_W-1:0] len,
  input  logic             dout_ready,
  output logic             sh_en,
  output logic             fsm_rst,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [7:0]       abort_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only WIDTH-1 history bits are ever needed. On the last edge the word is
  // {history, sdin}, and that word goes straight to dout.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sh_en_q, sh_en_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             dout_valid_q, dout_valid_d;
  logic [7:0]       abort_cnt_q, abort_cnt_d;
  logic [CNT_W-1:0] len_eff;

  // 0 and anything above WIDTH both mean a full-width frame.
  always_comb begin
    len_eff = CNT_W'(WIDTH);
    if (len != '0 && int'(len) <= WIDTH) len_eff = CNT_W'(len);
  end

  assign sr_next = {sr_q, sdin};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    dout_d       = dout_q;
    sh_en_d      = sh_en_q;
    fsm_rst_d    = fsm_rst_q;
    dout_valid_d = dout_valid_q;
    abort_cnt_d  = abort_cnt_q;
    case (state_q)
      S_IDLE: begin
        sh_en_d      = 1'b0;
        fsm_rst_d    = 1'b0;
        dout_valid_d = 1'b0;
        if (sync_state) begin
          // The history is cleared here, so bits above len_eff-1 are
          // already zero when the frame completes.
          cnt_d   = len_eff;
          sr_d    = '0;
          sh_en_d = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The last-bit check comes before the abort check. A sync drop on
        // the final edge still delivers the frame.
        if (cnt_q <= CNT_W'(1)) begin
          sr_d         = sr_next[WIDTH-2:0];
          cnt_d        = '0;
          sh_en_d      = 1'b0;
          dout_d       = sr_next;
          dout_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else if (!sync_state) begin
          cnt_d     = '0;
          sh_en_d   = 1'b0;
          fsm_rst_d = 1'b1;
          if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
          state_d   = S_ABORT;
        end else begin
          sr_d  = sr_next[WIDTH-2:0];
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_ABORT: begin
        fsm_rst_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      dout_q       <= '0;
      sh_en_q      <= 1'b0;
      fsm_rst_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      dout_q       <= dout_d;
      sh_en_q      <= sh_en_d;
      fsm_rst_q    <= fsm_rst_d;
      dout_valid_q <= dout_valid_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign sh_en      = sh_en_q;
  assign fsm_rst    = fsm_rst_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign abort_cnt  = abort_cnt_q;

endmodule
